// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_fifo_if
// Purpose : Receiver-side capture bus and FWFT read port of uart_rx_fifo
// Revision: 1.0
// ============================================================================
interface uart_rx_fifo_if #(
  parameter int W_DATA = 8
);
  logic [W_DATA-1:0] rx_dout;
  logic              rx_done;
  logic              parity_error;
  logic              framing_error;
  logic [W_DATA-1:0] rd_data;
  logic              rd_perr;
  logic              rd_ferr;
  logic              rd_valid;
  logic              rd_ready;

  // master: receiver + host side; slave: the FIFO itself
  modport master (
    output rx_dout, rx_done, parity_error, framing_error, rd_ready,
    input  rd_data, rd_perr, rd_ferr, rd_valid
  );

  modport slave (
    input  rx_dout, rx_done, parity_error, framing_error, rd_ready,
    output rd_data, rd_perr, rd_ferr, rd_valid
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_fifo
// Purpose : FWFT frame buffer behind a UART receiver with overflow/error status
// Revision: 1.0
// ============================================================================
module uart_rx_fifo #(
  parameter int W_DATA   = 8,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = 12,
  parameter int W_ERRCNT = 8
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  uart_rx_fifo_if.slave              bus,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full,
  output logic                       overflow,
  input  wire logic                  clr_overflow,
  output logic [W_ERRCNT-1:0]        err_cnt,
  input  wire logic                  clr_err_cnt
);
  localparam int c_AW = $clog2(DEPTH);
  localparam int c_PW = c_AW + 1;
  localparam int c_EW = W_DATA + 2;

  logic [c_EW-1:0]     r_mem [DEPTH];
  logic [c_PW-1:0]     r_wr_ptr;
  logic [c_PW-1:0]     r_rd_ptr;
  logic [c_PW-1:0]     r_count;
  logic                r_rd_valid;
  logic                r_almost_full;
  logic                r_overflow;
  logic [W_ERRCNT-1:0] r_err_cnt;

  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic                w_frame_err;
  logic [c_PW-1:0]     w_count_nxt;
  logic [c_EW-1:0]     w_head;

  // Extra wrap bit distinguishes full from empty when the address bits match
  assign w_full      = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                       (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);
  assign w_pop       = r_rd_valid && bus.rd_ready;
  assign w_push      = bus.rx_done && (!w_full || w_pop);
  assign w_drop      = bus.rx_done && w_full && !w_pop;
  assign w_frame_err = bus.parity_error || bus.framing_error;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + c_PW'(1);
      2'b01:   w_count_nxt = r_count - c_PW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= {bus.framing_error, bus.parity_error, bus.rx_dout};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_rd_valid    <= 1'b0;
      r_almost_full <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
      end
      r_count       <= w_count_nxt;
      r_rd_valid    <= (w_count_nxt != '0);
      r_almost_full <= (w_count_nxt >= c_PW'(AFULL_TH));
    end
  end

  // A drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (clr_err_cnt) begin
      r_err_cnt <= '0;
    end else if (w_push && w_frame_err && !(&r_err_cnt)) begin
      r_err_cnt <= r_err_cnt + W_ERRCNT'(1);
    end
  end

  assign w_head       = r_mem[r_rd_ptr[c_AW-1:0]];
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_valid ? w_head[W_DATA-1:0] : '0;
  assign bus.rd_perr  = r_rd_valid ? w_head[W_DATA]     : 1'b0;
  assign bus.rd_ferr  = r_rd_valid ? w_head[W_DATA+1]   : 1'b0;

  assign count       = r_count;
  assign almost_full = r_almost_full;
  assign overflow    = r_overflow;
  assign err_cnt     = r_err_cnt;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_fifo
// Purpose : Self-checking bench for uart_rx_fifo against a queue-based model
// Revision: 1.0
// ============================================================================
module tb_uart_rx_fifo;
  localparam int c_DEPTH = 16;
  localparam int c_AFULL = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_overflow = 1'b0;
  logic       clr_err_cnt = 1'b0;
  logic [4:0] count, count2;
  logic       almost_full, almost_full2;
  logic       overflow, overflow2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of {ferr, perr, data} plus status
  logic [9:0] mq[$];
  bit         m_ovf;
  int         m_err;
  int         m_err2;

  uart_rx_fifo_if #(.W_DATA(8)) bus ();
  uart_rx_fifo_if #(.W_DATA(8)) bus2 ();

  uart_rx_fifo #(.W_DATA(8), .DEPTH(c_DEPTH), .AFULL_TH(c_AFULL), .W_ERRCNT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .count        (count),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .err_cnt      (err_cnt),
    .clr_err_cnt  (clr_err_cnt)
  );

  uart_rx_fifo #(.W_DATA(8), .DEPTH(c_DEPTH), .AFULL_TH(c_AFULL), .W_ERRCNT(2)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus2.slave),
    .count        (count2),
    .almost_full  (almost_full2),
    .overflow     (overflow2),
    .clr_overflow (clr_overflow),
    .err_cnt      (err_cnt2),
    .clr_err_cnt  (clr_err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  task automatic set_idle();
    bus.rx_done = 1'b0;  bus.rx_dout = '0;  bus.parity_error = 1'b0;
    bus.framing_error = 1'b0;  bus.rd_ready = 1'b0;
    bus2.rx_done = 1'b0; bus2.rx_dout = '0; bus2.parity_error = 1'b0;
    bus2.framing_error = 1'b0; bus2.rd_ready = 1'b0;
    clr_overflow = 1'b0; clr_err_cnt = 1'b0;
  endtask

  task automatic model_clear();
    mq.delete();
    m_ovf  = 1'b0;
    m_err  = 0;
    m_err2 = 0;
  endtask

  // One clock: drive at negedge, advance the model across posedge, return at negedge
  task automatic step(input bit done, input logic [7:0] d, input bit pe, input bit fe,
                      input bit rdy, input bit cov, input bit cer);
    bit pop, acc;
    bus.rx_done = done;  bus.rx_dout = d;  bus.parity_error = pe;
    bus.framing_error = fe;  bus.rd_ready = rdy;
    bus2.rx_done = done; bus2.rx_dout = d; bus2.parity_error = pe;
    bus2.framing_error = fe; bus2.rd_ready = rdy;
    clr_overflow = cov; clr_err_cnt = cer;
    pop = (mq.size() != 0) && rdy;
    acc = done && ((mq.size() < c_DEPTH) || pop);
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back({fe, pe, d});
    if (done && !acc) m_ovf = 1'b1;
    else if (cov)     m_ovf = 1'b0;
    if (cer) begin
      m_err = 0; m_err2 = 0;
    end else if (acc && (pe || fe)) begin
      m_err  = (m_err  < 255) ? m_err + 1  : 255;
      m_err2 = (m_err2 < 3)   ? m_err2 + 1 : 3;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.rd_valid); end
    n_checks++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", bus.rd_data); end
    n_checks++; if ({almost_full, overflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {almost_full, overflow}); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_errcnt: got %0d expected 0", err_cnt); end
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_single();
    step(1, 8'hA5, 0, 0, 0, 0, 0);
    n_checks++; if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", bus.rd_valid); end
    n_checks++; if (bus.rd_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", bus.rd_data); end
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", count); end
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 0, 0, 0, 0, 0);
      n_checks++; if ({bus.rd_valid, bus.rd_data} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL single_stable[%0d]: got %b/%h expected 1/a5", i, bus.rd_valid, bus.rd_data); end
    end
    step(0, 8'h00, 0, 0, 1, 0, 0);
    n_checks++; if ({count, bus.rd_valid, bus.rd_data} !== {5'd0, 1'b0, 8'h00}) begin n_fail++; $display("FAIL single_pop: got cnt=%0d v=%b d=%h expected 0/0/00", count, bus.rd_valid, bus.rd_data); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < c_DEPTH; i++) begin
      step(1, 8'(i), 0, 0, 0, 0, 0);
      n_checks++; if (count !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1); end
      n_checks++; if (almost_full !== ((i + 1) >= c_AFULL)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, almost_full, (i + 1) >= c_AFULL); end
    end
    step(1, 8'hFF, 0, 0, 0, 0, 0);
    n_checks++; if ({overflow, count} !== {1'b1, 5'd16}) begin n_fail++; $display("FAIL ovf_set: got ovf=%b cnt=%0d expected 1/16", overflow, count); end
    for (int i = 0; i < c_DEPTH; i++) begin
      n_checks++; if (bus.rd_data !== 8'(i)) begin n_fail++; $display("FAIL drain_order[%0d]: got %h expected %h", i, bus.rd_data, 8'(i)); end
      step(0, 8'h00, 0, 0, 1, 0, 0);
    end
    n_checks++; if ({bus.rd_valid, count} !== {1'b0, 5'd0}) begin n_fail++; $display("FAIL drain_empty: got v=%b cnt=%0d expected 0/0", bus.rd_valid, count); end
    step(0, 8'h00, 0, 0, 0, 1, 0);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < c_DEPTH; i++) step(1, 8'h40 + 8'(i), 0, 0, 0, 0, 0);
    step(1, 8'h3C, 0, 0, 1, 0, 0);
    n_checks++; if ({count, overflow} !== {5'd16, 1'b0}) begin n_fail++; $display("FAIL fullpp: got cnt=%0d ovf=%b expected 16/0", count, overflow); end
    for (int i = 0; i < c_DEPTH; i++) begin
      n_checks++; if (bus.rd_data !== mq[0][7:0]) begin n_fail++; $display("FAIL fullpp_drain[%0d]: got %h expected %h", i, bus.rd_data, mq[0][7:0]); end
      if (i == c_DEPTH - 1) begin
        n_checks++; if (bus.rd_data !== 8'h3C) begin n_fail++; $display("FAIL fullpp_last: got %h expected 3c", bus.rd_data); end
      end
      step(0, 8'h00, 0, 0, 1, 0, 0);
    end
  endtask

  task automatic test_errors();
    logic [7:0] d[3];
    logic [1:0] fl[3];
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    fl[0] = 2'b01; fl[1] = 2'b10; fl[2] = 2'b11;
    step(0, 8'h00, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, d[i], fl[i][0], fl[i][1], 0, 0, 0);
    n_checks++; if (err_cnt !== 8'd3) begin n_fail++; $display("FAIL err_count: got %0d expected 3", err_cnt); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({bus.rd_ferr, bus.rd_perr, bus.rd_data} !== {fl[i], d[i]}) begin n_fail++; $display("FAIL err_flags[%0d]: got f=%b p=%b d=%h expected f=%b p=%b d=%h", i, bus.rd_ferr, bus.rd_perr, bus.rd_data, fl[i][1], fl[i][0], d[i]); end
      step(0, 8'h00, 0, 0, 1, 0, 0);
    end
    step(1, 8'h44, 1, 0, 0, 0, 1);
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL err_clr_wins: got %0d expected 0", err_cnt); end
    step(0, 8'h00, 0, 0, 1, 0, 0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) step(1, 8'h50 + 8'(i), 1, (i % 2) == 1, 0, 0, 0);
    n_checks++; if (err_cnt2 !== 2'(m_err2) || m_err2 != 3) begin n_fail++; $display("FAIL err_sat: got %0d expected 3", err_cnt2); end
    n_checks++; if (err_cnt !== 8'(m_err)) begin n_fail++; $display("FAIL err_nosat: got %0d expected %0d", err_cnt, m_err); end
    while (mq.size() < c_DEPTH) step(1, 8'h60 + 8'(mq.size()), 0, 0, 0, 0, 0);
    step(1, 8'hEE, 1, 1, 0, 1, 0);
    n_checks++; if ({overflow, overflow2} !== 2'b11) begin n_fail++; $display("FAIL ovf_set_wins: got %b%b expected 11", overflow, overflow2); end
    n_checks++; if (err_cnt2 !== 2'd3 || err_cnt !== 8'(m_err)) begin n_fail++; $display("FAIL drop_not_counted: got %0d/%0d expected 3/%0d", err_cnt2, err_cnt, m_err); end
    for (int i = 0; i < c_DEPTH; i++) step(0, 8'h00, 0, 0, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0, 1, 1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) step(1, 8'h70 + 8'(i), 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0, 1, 0, 0);
    set_idle();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({count, bus.rd_valid, bus.rd_data, overflow} !== {5'd0, 1'b0, 8'h00, 1'b0}) begin n_fail++; $display("FAIL async_reset: got cnt=%0d v=%b d=%h ovf=%b expected 0/0/00/0", count, bus.rd_valid, bus.rd_data, overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    step(1, 8'h5A, 0, 0, 0, 0, 0);
    n_checks++; if ({bus.rd_valid, bus.rd_data, count} !== {1'b1, 8'h5A, 5'd1}) begin n_fail++; $display("FAIL post_reset: got v=%b d=%h cnt=%0d expected 1/5a/1", bus.rd_valid, bus.rd_data, count); end
    step(0, 8'h00, 0, 0, 1, 0, 0);
  endtask

  task automatic test_random();
    logic [9:0] head;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(1, 0) == 1, 8'($urandom), $urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0,
           (i < 200) ? ($urandom_range(3, 0) == 0) : ($urandom_range(3, 0) != 0),
           $urandom_range(15, 0) == 0, $urandom_range(31, 0) == 0);
      head = (mq.size() != 0) ? mq[0] : 10'h000;
      n_checks++;
      if ({count, bus.rd_valid, almost_full, overflow} !== {5'(mq.size()), mq.size() != 0, mq.size() >= c_AFULL, m_ovf}) begin
        n_fail++;
        $display("FAIL rand_status[%0d]: got cnt=%0d v=%b af=%b ovf=%b expected cnt=%0d ovf=%b", i, count, bus.rd_valid, almost_full, overflow, mq.size(), m_ovf);
      end
      n_checks++;
      if ({bus.rd_ferr, bus.rd_perr, bus.rd_data} !== head) begin
        n_fail++;
        $display("FAIL rand_head[%0d]: got %h expected %h", i, {bus.rd_ferr, bus.rd_perr, bus.rd_data}, head);
      end
      n_checks++;
      if ({err_cnt, err_cnt2, count2} !== {8'(m_err), 2'(m_err2), 5'(mq.size())}) begin
        n_fail++;
        $display("FAIL rand_err[%0d]: got %0d/%0d expected %0d/%0d", i, err_cnt, err_cnt2, m_err, m_err2);
      end
    end
  endtask

  initial begin
    set_idle();
    model_clear();
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_errors();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
